// File: rtl/dp_ram_be.sv
// rtl/dp_ram_be.sv - dual-port byte-enable RAM with post-reset clear, read-valid tracking and port B write forwarding
module dp_ram_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_done,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic                    a_we,
    input  logic                    a_re,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic                    b_re,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    init_done_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_en;
    logic                    a_req;
    logic                    b_req;
    logic [DATA_WIDTH-1:0]   a_rd_d;
    logic [DATA_WIDTH-1:0]   b_rd_d;

    logic [DATA_WIDTH-1:0]   a_s1_data_q;
    logic                    a_s1_valid_q;
    logic [DATA_WIDTH-1:0]   b_s1_data_q;
    logic                    b_s1_valid_q;

    // Port traffic is only honoured once the clear sequence has finished.
    assign wr_en = init_done_q & a_we;
    assign a_req = init_done_q & a_re;
    assign b_req = init_done_q & b_re;

    // Clear FSM: walk every address once after reset, then stay ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    // Array update: zero fill while clearing, byte-lane writes from port A afterwards.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) begin
                    mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read words; port B optionally sees lanes being written by port A this cycle.
    always_comb begin
        a_rd_d = mem[a_addr];
        b_rd_d = mem[b_addr];
        if ((BYPASS != 0) && wr_en && (a_addr == b_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) begin
                    b_rd_d[8*i +: 8] = a_wdata[8*i +: 8];
                end
            end
        end
    end

    // First read stage: data captured only on a request so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_data_q  <= '0;
            a_s1_valid_q <= 1'b0;
            b_s1_data_q  <= '0;
            b_s1_valid_q <= 1'b0;
        end else begin
            a_s1_valid_q <= a_req;
            b_s1_valid_q <= b_req;
            if (a_req) begin
                a_s1_data_q <= a_rd_d;
            end
            if (b_req) begin
                b_s1_data_q <= b_rd_d;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] a_s2_data_q;
            logic                  a_s2_valid_q;
            logic [DATA_WIDTH-1:0] b_s2_data_q;
            logic                  b_s2_valid_q;

            // Extra output stage; advances only when the first stage holds a result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_s2_data_q  <= '0;
                    a_s2_valid_q <= 1'b0;
                    b_s2_data_q  <= '0;
                    b_s2_valid_q <= 1'b0;
                end else begin
                    a_s2_valid_q <= a_s1_valid_q;
                    b_s2_valid_q <= b_s1_valid_q;
                    if (a_s1_valid_q) begin
                        a_s2_data_q <= a_s1_data_q;
                    end
                    if (b_s1_valid_q) begin
                        b_s2_data_q <= b_s1_data_q;
                    end
                end
            end

            assign a_rdata  = a_s2_data_q;
            assign a_rvalid = a_s2_valid_q;
            assign b_rdata  = b_s2_data_q;
            assign b_rvalid = b_s2_valid_q;
        end else begin : g_lat1
            assign a_rdata  = a_s1_data_q;
            assign a_rvalid = a_s1_valid_q;
            assign b_rdata  = b_s1_data_q;
            assign b_rvalid = b_s1_valid_q;
        end
    endgenerate

    assign init_done = init_done_q;

endmodule

// File: tb/tb_dp_ram_be.sv
// tb/tb_dp_ram_be.sv - directed self-checking bench for dp_ram_be (latency 1 with forwarding, latency 2 without)
module tb_dp_ram_be;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic        a_we;
    logic        a_re;
    logic [3:0]  b_addr;
    logic        b_re;

    logic        d1_init_done, d1_a_rvalid, d1_b_rvalid;
    logic [31:0] d1_a_rdata, d1_b_rdata;
    logic        d2_init_done, d2_a_rvalid, d2_b_rvalid;
    logic [31:0] d2_a_rdata, d2_b_rdata;

    int n_assert;
    int n_fail;

    dp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .BYPASS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_done(d1_init_done),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be), .a_we(a_we), .a_re(a_re),
        .a_rdata(d1_a_rdata), .a_rvalid(d1_a_rvalid),
        .b_addr(b_addr), .b_re(b_re), .b_rdata(d1_b_rdata), .b_rvalid(d1_b_rvalid)
    );

    dp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .BYPASS(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .init_done(d2_init_done),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be), .a_we(a_we), .a_re(a_re),
        .a_rdata(d2_a_rdata), .a_rvalid(d2_a_rvalid),
        .b_addr(b_addr), .b_re(b_re), .b_rdata(d2_b_rdata), .b_rvalid(d2_b_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we = 1'b0; a_re = 1'b0; b_re = 1'b0;
        a_be = 4'h0; a_wdata = 32'h0; a_addr = 4'h0; b_addr = 4'h0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        a_we = 1'b1; a_addr = addr; a_wdata = data; a_be = be;
        cyc();
        idle();
    endtask

    // Same address on both ports; dut1 answers after one edge, dut2 after two.
    task automatic read_both(input string tag, input logic [3:0] addr,
                             input logic [31:0] exp1, input logic [31:0] exp2);
        a_re = 1'b1; b_re = 1'b1; a_addr = addr; b_addr = addr;
        cyc();
        idle();
        check_eq({tag, " d1 a_rvalid"}, {31'h0, d1_a_rvalid}, 32'h1);
        check_eq({tag, " d1 a_rdata"}, d1_a_rdata, exp1);
        check_eq({tag, " d1 b_rvalid"}, {31'h0, d1_b_rvalid}, 32'h1);
        check_eq({tag, " d1 b_rdata"}, d1_b_rdata, exp1);
        check_eq({tag, " d2 early valid"}, {31'h0, d2_a_rvalid}, 32'h0);
        cyc();
        check_eq({tag, " d1 a_rvalid pulse"}, {31'h0, d1_a_rvalid}, 32'h0);
        check_eq({tag, " d2 a_rvalid"}, {31'h0, d2_a_rvalid}, 32'h1);
        check_eq({tag, " d2 a_rdata"}, d2_a_rdata, exp2);
        check_eq({tag, " d2 b_rvalid"}, {31'h0, d2_b_rvalid}, 32'h1);
        check_eq({tag, " d2 b_rdata"}, d2_b_rdata, exp2);
    endtask

    initial begin
        int  ncyc;
        logic saw_v;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle();

        // Reset state
        repeat (3) cyc();
        check_eq("rst init_done", {31'h0, d1_init_done}, 32'h0);
        check_eq("rst d1 a_rdata", d1_a_rdata, 32'h0);
        check_eq("rst d1 b_rvalid", {31'h0, d1_b_rvalid}, 32'h0);
        check_eq("rst d2 b_rdata", d2_b_rdata, 32'h0);

        // Reset asserted mid-clear at counter 9
        rst_n = 1'b1;
        repeat (9) cyc();
        check_eq("midclear init_done", {31'h0, d1_init_done}, 32'h0);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst init_done", {31'h0, d1_init_done}, 32'h0);
        check_eq("midrst d1 a_rvalid", {31'h0, d1_a_rvalid}, 32'h0);
        cyc();
        rst_n = 1'b1;

        // Full clear with requests held active; none may take effect
        a_we = 1'b1; a_re = 1'b1; b_re = 1'b1;
        a_addr = 4'd2; b_addr = 4'd2; a_wdata = 32'hFFFF_FFFF; a_be = 4'hF;
        ncyc  = 0;
        saw_v = 1'b0;
        while (ncyc < 40) begin
            cyc();
            ncyc++;
            if (d1_a_rvalid | d1_b_rvalid | d2_a_rvalid | d2_b_rvalid) saw_v = 1'b1;
            if (d1_init_done) break;
        end
        idle();
        check_eq("clear cycles", ncyc, 32'd16);
        check_eq("d2 init_done", {31'h0, d2_init_done}, 32'h1);
        check_eq("rvalid during clear", {31'h0, saw_v}, 32'h0);

        // Sweep all addresses on both ports back to back; all must read zero
        for (int k = 0; k < 16; k++) begin
            a_re = 1'b1; b_re = 1'b1; a_addr = 4'(k); b_addr = 4'(15 - k);
            cyc();
            check_eq("sweep d1 a_rvalid", {31'h0, d1_a_rvalid}, 32'h1);
            check_eq("sweep d1 a_rdata", d1_a_rdata, 32'h0);
            check_eq("sweep d1 b_rvalid", {31'h0, d1_b_rvalid}, 32'h1);
            check_eq("sweep d1 b_rdata", d1_b_rdata, 32'h0);
            if (k > 0) begin
                check_eq("sweep d2 b_rvalid", {31'h0, d2_b_rvalid}, 32'h1);
                check_eq("sweep d2 a_rdata", d2_a_rdata, 32'h0);
            end
        end
        idle();
        cyc();
        check_eq("sweep end d1 a_rvalid", {31'h0, d1_a_rvalid}, 32'h0);
        check_eq("sweep end d2 a_rvalid", {31'h0, d2_a_rvalid}, 32'h1);
        cyc();
        check_eq("sweep end d2 b_rvalid", {31'h0, d2_b_rvalid}, 32'h0);

        // Byte enables
        wr(4'd5, 32'hAABB_CCDD, 4'b1111);
        wr(4'd5, 32'h1122_3344, 4'b0101);
        wr(4'd5, 32'h9999_9999, 4'b0000);
        read_both("byte_en", 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);

        // Write collision with port B read
        a_we = 1'b1; a_addr = 4'd3; a_wdata = 32'hDEAD_BEEF; a_be = 4'b0011;
        b_re = 1'b1; b_addr = 4'd3;
        cyc();
        idle();
        check_eq("coll d1 b_rvalid", {31'h0, d1_b_rvalid}, 32'h1);
        check_eq("coll bypass b_rdata", d1_b_rdata, 32'h0000_BEEF);
        cyc();
        check_eq("coll d2 b_rvalid", {31'h0, d2_b_rvalid}, 32'h1);
        check_eq("coll nobypass b_rdata", d2_b_rdata, 32'h0000_0000);
        read_both("coll after", 4'd3, 32'h0000_BEEF, 32'h0000_BEEF);

        // Port A read-before-write
        wr(4'd7, 32'h1234_5678, 4'hF);
        a_we = 1'b1; a_re = 1'b1; a_addr = 4'd7; a_wdata = 32'hCAFE_F00D; a_be = 4'hF;
        cyc();
        idle();
        check_eq("rbw d1 a_rdata", d1_a_rdata, 32'h1234_5678);
        cyc();
        check_eq("rbw d2 a_rdata", d2_a_rdata, 32'h1234_5678);
        check_eq("rbw d1 hold", d1_a_rdata, 32'h1234_5678);
        read_both("rbw after", 4'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Latency: three back-to-back port B reads at 1, 2, 3
        wr(4'd1, 32'h0101_0101, 4'hF);
        wr(4'd2, 32'h0202_0202, 4'hF);
        b_re = 1'b1; b_addr = 4'd1;
        cyc();
        check_eq("lat n d1 valid", {31'h0, d1_b_rvalid}, 32'h1);
        check_eq("lat n d1 data", d1_b_rdata, 32'h0101_0101);
        check_eq("lat n d2 valid", {31'h0, d2_b_rvalid}, 32'h0);
        b_addr = 4'd2;
        cyc();
        check_eq("lat n1 d1 data", d1_b_rdata, 32'h0202_0202);
        check_eq("lat n1 d2 valid", {31'h0, d2_b_rvalid}, 32'h1);
        check_eq("lat n1 d2 data", d2_b_rdata, 32'h0101_0101);
        b_addr = 4'd3;
        cyc();
        idle();
        check_eq("lat n2 d1 data", d1_b_rdata, 32'h0000_BEEF);
        check_eq("lat n2 d2 data", d2_b_rdata, 32'h0202_0202);
        cyc();
        check_eq("lat n3 d1 valid", {31'h0, d1_b_rvalid}, 32'h0);
        check_eq("lat n3 d1 hold", d1_b_rdata, 32'h0000_BEEF);
        check_eq("lat n3 d2 valid", {31'h0, d2_b_rvalid}, 32'h1);
        check_eq("lat n3 d2 data", d2_b_rdata, 32'h0000_BEEF);
        cyc();
        check_eq("lat n4 d2 valid", {31'h0, d2_b_rvalid}, 32'h0);
        check_eq("lat n4 d2 hold", d2_b_rdata, 32'h0000_BEEF);

        // Asynchronous reset while ready clears outputs without a clock edge
        #3 rst_n = 1'b0;
        #1;
        check_eq("async rst d1 a_rdata", d1_a_rdata, 32'h0);
        check_eq("async rst d1 b_rdata", d1_b_rdata, 32'h0);
        check_eq("async rst d2 a_rdata", d2_a_rdata, 32'h0);
        check_eq("async rst init_done", {31'h0, d1_init_done}, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
